// File: rtl/acc_pkg.sv
// Shared types and constants for the product accumulator and its reusable saturating adder.
package acc_pkg;

   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_DONE  = 1'b1
   } state_t;

   localparam int DEF_PROD_W = 17;
   localparam int DEF_ACC_W  = 24;
   localparam int DEF_NTERMS = 8;
   localparam int DEF_CNT_W  = 8;

   // All-ones value of a w-bit unsigned word, the clamp point of the saturating adder.
   function automatic longint unsigned sat_max(input int w);
      return (64'd1 << w) - 64'd1;
   endfunction

endpackage

// File: rtl/sat_add.sv
// Combinational W-bit unsigned saturating adder; ovf flags that the result was clamped.
module sat_add
   import acc_pkg::*;
#(
   parameter int W = DEF_ACC_W
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum,
   output logic         ovf
);

   logic [W:0] full_sum;

   assign full_sum = {1'b0, a} + {1'b0, b};
   assign ovf      = full_sum[W];
   assign sum      = full_sum[W] ? W'(sat_max(W)) : full_sum[W-1:0];

endmodule

// File: rtl/product_accumulator.sv
// Sums NTERMS unsigned products into one saturated frame result, presented on a
// valid/ready output that holds the result until the consumer takes it.
module product_accumulator
   import acc_pkg::*;
#(
   parameter int PROD_W = DEF_PROD_W,
   parameter int ACC_W  = DEF_ACC_W,
   parameter int NTERMS = DEF_NTERMS,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              prod_valid,
   input  logic [PROD_W-1:0] prod_data,
   output logic              prod_ready,
   output logic              acc_valid,
   output logic [ACC_W-1:0]  acc_data,
   output logic              acc_ovf,
   input  logic              acc_ready,
   output logic [CNT_W-1:0]  term_cnt
);

   state_t             state_reg;
   logic [ACC_W-1:0]   acc_reg;
   logic               ovf_reg;
   logic [CNT_W-1:0]   term_cnt_reg;
   logic               acc_valid_reg;
   logic [ACC_W-1:0]   acc_data_reg;
   logic               acc_ovf_reg;

   logic [ACC_W-1:0]   prod_ext;
   logic [ACC_W-1:0]   sum_next;
   logic               add_ovf;
   logic               ovf_next;
   logic               prod_fire;
   logic               out_fire;
   logic               last_term;

   assign prod_ext  = ACC_W'(prod_data);
   assign prod_fire = prod_valid & prod_ready;
   assign out_fire  = acc_valid_reg & acc_ready;
   assign last_term = (term_cnt_reg == CNT_W'(NTERMS - 1));
   assign ovf_next  = ovf_reg | add_ovf;

   sat_add #(
      .W (ACC_W)
   ) u_sat_add (
      .a   (acc_reg),
      .b   (prod_ext),
      .sum (sum_next),
      .ovf (add_ovf)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= ST_ACCUM;
         acc_reg       <= '0;
         ovf_reg       <= 1'b0;
         term_cnt_reg  <= '0;
         acc_valid_reg <= 1'b0;
         acc_data_reg  <= '0;
         acc_ovf_reg   <= 1'b0;
      end else if (clr) begin
         // Any product offered alongside clr is dropped on purpose.
         state_reg     <= ST_ACCUM;
         acc_reg       <= '0;
         ovf_reg       <= 1'b0;
         term_cnt_reg  <= '0;
         acc_valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            ST_ACCUM: begin
               if (prod_fire) begin
                  acc_reg <= sum_next;
                  ovf_reg <= ovf_next;
                  if (last_term) begin
                     state_reg     <= ST_DONE;
                     acc_data_reg  <= sum_next;
                     acc_ovf_reg   <= ovf_next;
                     acc_valid_reg <= 1'b1;
                     term_cnt_reg  <= '0;
                  end else begin
                     term_cnt_reg  <= term_cnt_reg + 1'b1;
                  end
               end
            end
            ST_DONE: begin
               if (out_fire) begin
                  state_reg     <= ST_ACCUM;
                  acc_reg       <= '0;
                  ovf_reg       <= 1'b0;
                  acc_valid_reg <= 1'b0;
               end
            end
            default: state_reg <= ST_ACCUM;
         endcase
      end
   end

   assign prod_ready = (state_reg == ST_ACCUM);
   assign acc_valid  = acc_valid_reg;
   assign acc_data   = acc_data_reg;
   assign acc_ovf    = acc_ovf_reg;
   assign term_cnt   = term_cnt_reg;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: four parameterisations share clk, rst_n and clr.
module tb_product_accumulator;

   logic clk = 1'b0;
   logic rst_n;
   logic clr;

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // NTERMS=4, ACC_W=24
   logic v4, r4, av4, ao4, ar4;
   logic [16:0] d4;
   logic [23:0] ad4;
   logic [7:0]  tc4;
   // NTERMS=2, ACC_W=24
   logic v2, r2, av2, ao2, ar2;
   logic [16:0] d2;
   logic [23:0] ad2;
   logic [7:0]  tc2;
   // NTERMS=3, ACC_W=18
   logic vs, rs, avs, aos, ars;
   logic [16:0] ds;
   logic [17:0] ads;
   logic [7:0]  tcs;
   // NTERMS=1, ACC_W=24
   logic v1, r1, av1, ao1, ar1;
   logic [16:0] d1;
   logic [23:0] ad1;
   logic [7:0]  tc1;

   product_accumulator #(.PROD_W(17), .ACC_W(24), .NTERMS(4), .CNT_W(8)) u_n4 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .prod_valid(v4), .prod_data(d4),
      .prod_ready(r4), .acc_valid(av4), .acc_data(ad4), .acc_ovf(ao4),
      .acc_ready(ar4), .term_cnt(tc4));

   product_accumulator #(.PROD_W(17), .ACC_W(24), .NTERMS(2), .CNT_W(8)) u_n2 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .prod_valid(v2), .prod_data(d2),
      .prod_ready(r2), .acc_valid(av2), .acc_data(ad2), .acc_ovf(ao2),
      .acc_ready(ar2), .term_cnt(tc2));

   product_accumulator #(.PROD_W(17), .ACC_W(18), .NTERMS(3), .CNT_W(8)) u_sat (
      .clk(clk), .rst_n(rst_n), .clr(clr), .prod_valid(vs), .prod_data(ds),
      .prod_ready(rs), .acc_valid(avs), .acc_data(ads), .acc_ovf(aos),
      .acc_ready(ars), .term_cnt(tcs));

   product_accumulator #(.PROD_W(17), .ACC_W(24), .NTERMS(1), .CNT_W(8)) u_n1 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .prod_valid(v1), .prod_data(d1),
      .prod_ready(r1), .acc_valid(av1), .acc_data(ad1), .acc_ovf(ao1),
      .acc_ready(ar1), .term_cnt(tc1));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end else begin
         $display("ok   %s = %0d", tag, got);
      end
   endtask

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; clr = 1'b0;
      v4 = 0; d4 = '0; ar4 = 1;
      v2 = 0; d2 = '0; ar2 = 1;
      vs = 0; ds = '0; ars = 1;
      v1 = 0; d1 = '0; ar1 = 1;
      tick();
      tick();
      chk("rst_acc_valid", 32'(av4), 0);
      chk("rst_acc_data", 32'(ad4), 0);
      chk("rst_acc_ovf", 32'(ao4), 0);
      chk("rst_term_cnt", 32'(tc4), 0);
      chk("rst_prod_ready", 32'(r4), 1);
      rst_n = 1'b1;

      // Basic frame, NTERMS=4: 4 x 3969 = 15876
      v4 = 1; d4 = 17'd3969;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (i < 3) chk("basic_term_cnt", 32'(tc4), 32'(i + 1));
      end
      v4 = 0;
      chk("basic_valid", 32'(av4), 1);
      chk("basic_data", 32'(ad4), 15876);
      chk("basic_ovf", 32'(ao4), 0);
      chk("basic_ready_low", 32'(r4), 0);
      chk("basic_cnt_wrap", 32'(tc4), 0);
      tick();
      chk("basic_valid_drop", 32'(av4), 0);
      chk("basic_ready_back", 32'(r4), 1);

      // Backpressure, NTERMS=2: 100+200 held while acc_ready=0, 7 waits
      ar2 = 0; v2 = 1; d2 = 17'd100;
      tick();
      d2 = 17'd200;
      tick();
      d2 = 17'd7;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) tick();
         chk("bp_valid", 32'(av2), 1);
         chk("bp_data", 32'(ad2), 300);
         chk("bp_ready_low", 32'(r2), 0);
      end
      ar2 = 1;
      tick();
      chk("bp_xfer_valid", 32'(av2), 0);
      chk("bp_xfer_cnt", 32'(tc2), 0);
      tick();
      chk("bp_seven_taken", 32'(tc2), 1);
      v2 = 0;

      // Saturation, ACC_W=18 NTERMS=3
      vs = 1; ds = 17'd131071;
      tick(); tick(); tick();
      chk("sat_valid", 32'(avs), 1);
      chk("sat_data", 32'(ads), 262143);
      chk("sat_ovf", 32'(aos), 1);
      ds = 17'd1;
      tick();
      chk("sat_done_ignore_cnt", 32'(tcs), 0);
      tick(); tick(); tick();
      vs = 0;
      chk("sat_next_valid", 32'(avs), 1);
      chk("sat_next_data", 32'(ads), 3);
      chk("sat_next_ovf", 32'(aos), 0);
      tick();

      // clr mid-frame, NTERMS=4: 30 dropped, result 1+2+3+4
      v4 = 1; d4 = 17'd10;
      tick();
      d4 = 17'd20;
      tick();
      chk("clr_pre_cnt", 32'(tc4), 2);
      d4 = 17'd30; clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("clr_cnt0", 32'(tc4), 0);
      chk("clr_valid", 32'(av4), 0);
      for (int i = 1; i <= 4; i++) begin
         d4 = 17'(i);
         tick();
         if (i < 4) chk("clr_cnt_seq", 32'(tc4), 32'(i));
      end
      v4 = 0;
      chk("clr_result_valid", 32'(av4), 1);
      chk("clr_result_data", 32'(ad4), 10);
      tick();

      // Reset mid-frame
      v4 = 1; d4 = 17'd5;
      tick(); tick();
      chk("rmid_pre_cnt", 32'(tc4), 2);
      rst_n = 1'b0; v4 = 0;
      tick();
      chk("rmid_cnt", 32'(tc4), 0);
      chk("rmid_valid", 32'(av4), 0);
      chk("rmid_ready", 32'(r4), 1);
      rst_n = 1'b1;
      tick();
      chk("rmid_no_spurious", 32'(av4), 0);

      // Reset while a result is held
      ar4 = 0; v4 = 1; d4 = 17'd6;
      tick(); tick(); tick(); tick();
      v4 = 0;
      chk("rdone_valid", 32'(av4), 1);
      chk("rdone_data", 32'(ad4), 24);
      rst_n = 1'b0;
      tick();
      chk("rdone_valid_clr", 32'(av4), 0);
      chk("rdone_data_clr", 32'(ad4), 0);
      chk("rdone_ready", 32'(r4), 1);
      rst_n = 1'b1; ar4 = 1;
      tick();
      chk("rdone_no_spurious", 32'(av4), 0);

      // NTERMS=1 with idle gap
      v1 = 1; d1 = 17'd5;
      tick();
      v1 = 0;
      chk("n1_first_valid", 32'(av1), 1);
      chk("n1_first_data", 32'(ad1), 5);
      tick();
      chk("n1_first_drop", 32'(av1), 0);
      tick(); tick();
      v1 = 1; d1 = 17'd9;
      tick();
      v1 = 0;
      chk("n1_second_valid", 32'(av1), 1);
      chk("n1_second_data", 32'(ad1), 9);
      tick();
      chk("n1_second_drop", 32'(av1), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
